// File: rtl/ni_local_tx.sv
// Local-port flit injector: turns a descriptor plus payload stream into
// header/size/payload flits on the router local input, under credit flow control.
//
// state   | meaning
// S_IDLE  | waiting for a descriptor; output register may hold the last flit
// S_SIZE  | header is in the output register, size flit goes next
// S_PAYLOAD | streaming payload flits, cnt_q counts the ones still owed
module ni_local_tx #(
  parameter int TAM_FLIT = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [TAM_FLIT-1:0] req_target,
  input  logic [TAM_FLIT-1:0] req_size,
  input  logic                pl_valid,
  output logic                pl_ready,
  input  logic [TAM_FLIT-1:0] pl_data,
  output logic                tx,
  output logic [TAM_FLIT-1:0] data_out,
  output logic                clock_tx,
  input  logic                credit_i,
  output logic                busy,
  output logic [15:0]         pkt_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SIZE    = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t              state_q;
  logic                tx_q;
  logic [TAM_FLIT-1:0] data_q;
  logic [TAM_FLIT-1:0] cnt_q;
  logic                last_q;
  logic                busy_q;
  logic [15:0]         pkt_q;

  logic load;
  logic req_acc;
  logic pl_acc;
  logic done;

  // The output register is free when empty or when its flit leaves this edge.
  assign load      = !tx_q || credit_i;
  assign req_ready = (state_q == S_IDLE) && load;
  assign pl_ready  = (state_q == S_PAYLOAD) && load;
  assign req_acc   = req_valid && req_ready;
  assign pl_acc    = pl_valid && pl_ready;
  assign done      = tx_q && credit_i && last_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      tx_q    <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      pkt_q   <= '0;
    end else begin
      if (done) pkt_q <= pkt_q + 16'd1;

      // A descriptor accepted on the completion edge keeps busy asserted.
      if (req_acc)   busy_q <= 1'b1;
      else if (done) busy_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (req_acc) begin
            data_q  <= req_target;
            tx_q    <= 1'b1;
            cnt_q   <= req_size;
            last_q  <= 1'b0;
            state_q <= S_SIZE;
          end else if (load) begin
            tx_q   <= 1'b0;
            last_q <= 1'b0;
          end
        end
        S_SIZE: begin
          if (load) begin
            data_q <= cnt_q;
            tx_q   <= 1'b1;
            if (cnt_q == '0) begin
              last_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              state_q <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (pl_acc) begin
            data_q <= pl_data;
            tx_q   <= 1'b1;
            if (cnt_q != '0) cnt_q <= cnt_q - TAM_FLIT'(1);
            if (cnt_q == TAM_FLIT'(1)) begin
              last_q  <= 1'b1;
              state_q <= S_IDLE;
            end
          end else if (load) begin
            tx_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx        = tx_q;
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign pkt_count = pkt_q;
  assign clock_tx  = clock;

endmodule

// File: tb/tb_ni_local_tx.sv
// Bench for ni_local_tx: directed scenarios plus a randomized run scored
// against an expected flit stream built from the packet list.
module tb_ni_local_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_target = '0;
  logic [15:0] req_size = '0;
  logic        pl_valid = 1'b0;
  logic        pl_ready;
  logic [15:0] pl_data = '0;
  logic        tx;
  logic [15:0] data_out;
  logic        clock_tx;
  logic        credit_i = 1'b1;
  logic        busy;
  logic [15:0] pkt_count;

  ni_local_tx #(.TAM_FLIT(16)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .req_size(req_size),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .tx(tx), .data_out(data_out), .clock_tx(clock_tx),
    .credit_i(credit_i), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_pass = 0;

  logic [15:0] req_tq[$];
  logic [15:0] req_sq[$];
  logic [15:0] pl_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  bit          tx_tr[$];
  bit          busy_tr[$];
  int          req_idx = 0;
  int          pl_idx = 0;
  bit          pl_gate = 1'b1;
  bit          rnd_mode = 1'b0;
  bit          pl_rdy_seen = 1'b0;
  bit          req_fire = 1'b0;
  bit          pl_fire = 1'b0;
  int          exp_pkts = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor: sample mid-cycle what will happen on the next rising edge.
  always @(negedge clock) begin
    req_fire = !reset && req_valid && req_ready;
    pl_fire  = !reset && pl_valid && pl_ready;
    if (!reset && tx && credit_i) got_q.push_back(data_out);
    tx_tr.push_back(tx);
    busy_tr.push_back(busy);
    if (pl_ready) pl_rdy_seen = 1'b1;
  end

  // Source side: present descriptors and payload from the queues.
  always @(posedge clock) begin
    #2;
    if (req_fire) req_idx++;
    if (pl_fire) pl_idx++;
    if (rnd_mode) begin
      pl_gate  = ($urandom_range(0, 3) != 0);
      credit_i = ($urandom_range(0, 3) != 0);
    end
    req_valid  = (req_idx < int'(req_tq.size()));
    req_target = req_valid ? req_tq[req_idx] : 16'h0;
    req_size   = req_valid ? req_sq[req_idx] : 16'h0;
    pl_valid   = pl_gate && (pl_idx < int'(pl_q.size()));
    pl_data    = (pl_idx < int'(pl_q.size())) ? pl_q[pl_idx] : 16'h0;
  end

  // Expected wire stream of a packet: target, size, then payload in order.
  task automatic add_pkt(input logic [15:0] t, input int s, input logic [15:0] base, input bit rnd);
    logic [15:0] w;
    req_tq.push_back(t);
    req_sq.push_back(16'(s));
    exp_q.push_back(t);
    exp_q.push_back(16'(s));
    for (int i = 0; i < s; i++) begin
      w = rnd ? 16'($urandom) : base + 16'(i + 1);
      pl_q.push_back(w);
      exp_q.push_back(w);
    end
  endtask

  task automatic clear_tr();
    got_q.delete();
    exp_q.delete();
    tx_tr.delete();
    busy_tr.delete();
    pl_rdy_seen = 1'b0;
  endtask

  function automatic int n_tx();
    int n = 0;
    foreach (tx_tr[i]) if (tx_tr[i]) n++;
    return n;
  endfunction

  function automatic int n_busy();
    int n = 0;
    foreach (busy_tr[i]) if (busy_tr[i]) n++;
    return n;
  endfunction

  // Idle cycles between the first and last valid flit.
  function automatic int n_gaps();
    int first = -1;
    int last = -1;
    int n = 0;
    foreach (tx_tr[i]) if (tx_tr[i]) begin
      if (first < 0) first = i;
      last = i;
    end
    for (int i = first; i <= last && first >= 0; i++) if (!tx_tr[i]) n++;
    return n;
  endfunction

  task automatic check_flits(input string tag);
    int n;
    check({tag, "_nflits"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_flit"}, got_q[i], exp_q[i]);
  endtask

  // Runs n cycles starting now; credit and pl_gate low over the given ranges.
  task automatic run(input int n, input int cr_a, input int cr_b, input int pg_a, input int pg_b);
    for (int c = 0; c < n; c++) begin
      credit_i = !(c >= cr_a && c <= cr_b);
      pl_gate  = !(c >= pg_a && c <= pg_b);
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fin;
    repeat (3) @(posedge clock);
    #1;
    check("rst_tx", tx, 1'b0);
    check("rst_data", data_out, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_pkt_count", pkt_count, 16'h0);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_pl_ready", pl_ready, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Reset during the second payload flit, then a clean packet.
    clear_tr();
    add_pkt(16'h0203, 3, 16'h00B0, 1'b0);
    run(4, -1, -1, -1, -1);
    reset = 1'b1;
    credit_i = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_tx", tx, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_pkt_count", pkt_count, 16'(exp_pkts));
    reset = 1'b0;
    pl_idx = pl_q.size();
    exp_q.delete();
    exp_q = '{16'h0203, 16'h0003, 16'h00B1};
    check_flits("midrst");
    clear_tr();
    add_pkt(16'h0304, 2, 16'h00C0, 1'b0);
    run(6, -1, -1, -1, -1);
    exp_pkts++;
    check_flits("after_rst");
    check("after_rst_pkt_count", pkt_count, 16'(exp_pkts));

    // Basic packet, full credit.
    clear_tr();
    add_pkt(16'h0102, 3, 16'h00A0, 1'b0);
    run(8, -1, -1, -1, -1);
    exp_pkts++;
    check_flits("basic");
    check("basic_busy_cycles", n_busy(), 5);
    check("basic_tx_cycles", n_tx(), 5);
    check("basic_gaps", n_gaps(), 0);
    check("basic_pkt_count", pkt_count, 16'(exp_pkts));

    // Credit withheld for three cycles while the size flit is presented.
    clear_tr();
    add_pkt(16'h0102, 3, 16'h00A0, 1'b0);
    run(11, 2, 4, -1, -1);
    exp_pkts++;
    check_flits("stall");
    check("stall_busy_cycles", n_busy(), 8);
    check("stall_hold_cycles", n_tx(), 8);
    check("stall_pkt_count", pkt_count, 16'(exp_pkts));

    // Empty packet.
    clear_tr();
    add_pkt(16'h0000, 0, 16'h0, 1'b0);
    run(5, -1, -1, -1, -1);
    exp_pkts++;
    check_flits("size0");
    check("size0_pl_ready_seen", pl_rdy_seen, 1'b0);
    check("size0_busy_cycles", n_busy(), 2);
    check("size0_pkt_count", pkt_count, 16'(exp_pkts));

    // Two descriptors back to back.
    clear_tr();
    add_pkt(16'h0011, 1, 16'h00D0, 1'b0);
    add_pkt(16'h0022, 1, 16'h00E0, 1'b0);
    run(9, -1, -1, -1, -1);
    exp_pkts += 2;
    check_flits("b2b");
    check("b2b_tx_cycles", n_tx(), 6);
    check("b2b_gaps", n_gaps(), 0);
    check("b2b_busy_cycles", n_busy(), 6);
    check("b2b_pkt_count", pkt_count, 16'(exp_pkts));

    // Payload source pauses for two cycles after the first payload flit.
    clear_tr();
    add_pkt(16'h0405, 3, 16'h00F0, 1'b0);
    run(10, -1, -1, 3, 4);
    exp_pkts++;
    check_flits("bubble");
    check("bubble_gaps", n_gaps(), 2);
    check("bubble_busy_cycles", n_busy(), 7);
    check("bubble_pkt_count", pkt_count, 16'(exp_pkts));

    // Randomized credit and payload availability.
    clear_tr();
    for (int p = 0; p < 40; p++)
      add_pkt({8'h00, 8'($urandom)}, $urandom_range(0, 6), 16'h0, 1'b1);
    exp_pkts += 40;
    rnd_mode = 1'b1;
    fin = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      @(posedge clock);
      #1;
      if (pkt_count == 16'(exp_pkts) && req_idx == int'(req_tq.size())) fin = 1'b1;
    end
    rnd_mode = 1'b0;
    credit_i = 1'b1;
    pl_gate = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rnd_completed", fin, 1'b1);
    check_flits("rnd");
    check("rnd_pkt_count", pkt_count, 16'(exp_pkts));
    check("rnd_busy_end", busy, 1'b0);
    check("rnd_tx_end", tx, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
